// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable integer clock divider with per-channel
// glitch-free start/stop and ratio changes deferred to period boundaries.
module clock_divider_multi #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 4
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH-1:0]       div_ld,
   input  logic [NUM_CH*CNT_W-1:0] div_val,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       run,
   output logic [NUM_CH-1:0]       pend
);

   localparam int              DEF_CLAMP = (DEF_DIV < 2) ? 2 : DEF_DIV;
   localparam logic [CNT_W-1:0] DEF_N    = CNT_W'(DEF_CLAMP);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

   genvar g;
   for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0] n_q, p_q, cnt_q;
      logic [CNT_W-1:0] n_d, p_d, cnt_d;
      logic [CNT_W-1:0] raw_val, ld_val, h_d;
      logic             pend_q, run_q, clk_q, tick_q;
      logic             pend_d, run_d, clk_d, tick_d;
      logic             at_bnd;

      always_comb begin
         raw_val = div_val[g*CNT_W +: CNT_W];
         ld_val  = (raw_val < TWO) ? TWO : raw_val;
         at_bnd  = (cnt_q == n_q - ONE);
         n_d     = n_q;
         p_d     = p_q;
         pend_d  = pend_q;
         cnt_d   = cnt_q;
         run_d   = run_q;
         tick_d  = 1'b0;
         if (at_bnd && ch_en[g]) begin
            cnt_d  = '0;
            run_d  = 1'b1;
            tick_d = 1'b1;
            if (pend_q) begin
               n_d    = p_q;
               pend_d = 1'b0;
            end
            // A load on the boundary edge is queued for the following boundary
            if (div_ld[g]) begin
               p_d    = ld_val;
               pend_d = 1'b1;
            end
         end else if (at_bnd) begin
            run_d = 1'b0;
            if (div_ld[g]) begin
               if (run_q) begin
                  p_d    = ld_val;
                  pend_d = 1'b1;
               end else begin
                  n_d    = ld_val;
                  cnt_d  = ld_val - ONE;
                  pend_d = 1'b0;
               end
            end
         end else begin
            cnt_d = cnt_q + ONE;
            if (div_ld[g]) begin
               p_d    = ld_val;
               pend_d = 1'b1;
            end
         end
         h_d   = n_d - (n_d >> 1);
         clk_d = run_d && (cnt_d < h_d);
      end

      always_ff @(posedge clk_in or posedge rst) begin
         if (rst) begin
            n_q    <= DEF_N;
            p_q    <= DEF_N;
            cnt_q  <= DEF_N - ONE;
            pend_q <= 1'b0;
            run_q  <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            n_q    <= n_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            run_q  <= run_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
         end
      end

      assign clk_out[g] = clk_q;
      assign tick[g]    = tick_q;
      assign run[g]     = run_q;
      assign pend[g]    = pend_q;
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (NUM_CH=2, CNT_W=16, DEF_DIV=4).
module tb_clock_divider_multi;

   logic        clk_in;
   logic        rst;
   logic [1:0]  ch_en;
   logic [1:0]  div_ld;
   logic [31:0] div_val;
   logic [1:0]  clk_out;
   logic [1:0]  tick;
   logic [1:0]  run;
   logic [1:0]  pend;

   int checks;
   int failures;

   clock_divider_multi #(.NUM_CH(2), .CNT_W(16), .DEF_DIV(4)) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .ch_en   (ch_en),
      .div_ld  (div_ld),
      .div_val (div_val),
      .clk_out (clk_out),
      .tick    (tick),
      .run     (run),
      .pend    (pend)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] ec, input logic [1:0] et,
                      input logic [1:0] er, input logic [1:0] ep);
      checks++;
      assert ({clk_out, tick, run, pend} === {ec, et, er, ep})
      else begin
         failures++;
         $error("FAIL %s observed clk=%b tick=%b run=%b pend=%b expected clk=%b tick=%b run=%b pend=%b",
                tag, clk_out, tick, run, pend, ec, et, er, ep);
      end
   endtask

   // Reference waveform: phase k of a period of n cycles
   function automatic logic mclk(input int k, input int n);
      return (k % n) < (n - n / 2);
   endfunction

   function automatic logic mtick(input int k, input int n);
      return (k % n) == 0;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      ch_en    = 2'b00;
      div_ld   = 2'b00;
      div_val  = '0;
      cyc();
      cyc();
      chk("reset", 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      cyc();
      chk("idle_after_reset", 2'b00, 2'b00, 2'b00, 2'b00);

      // default ratio 4 on ch0
      ch_en = 2'b01;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk($sformatf("def4_k%0d", k), {1'b0, mclk(k, 4)}, {1'b0, mtick(k, 4)}, 2'b01, 2'b00);
      end
      ch_en = 2'b00;
      cyc();
      chk("def4_stop", 2'b00, 2'b00, 2'b00, 2'b00);

      // idle load 5 then enable
      div_ld  = 2'b01;
      div_val = {16'd0, 16'd5};
      cyc();
      chk("idle_load5", 2'b00, 2'b00, 2'b00, 2'b00);
      div_ld = 2'b00;
      ch_en  = 2'b01;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk($sformatf("n5_k%0d", k), {1'b0, mclk(k, 5)}, {1'b0, mtick(k, 5)}, 2'b01, 2'b00);
      end

      // load 4 on the boundary edge: current period stays 5
      div_ld  = 2'b01;
      div_val = {16'd0, 16'd4};
      cyc();
      chk("bnd_load4_k0", 2'b01, 2'b01, 2'b01, 2'b01);
      div_ld = 2'b00;
      for (int k = 1; k < 5; k++) begin
         cyc();
         chk($sformatf("bnd_load4_k%0d", k), {1'b0, mclk(k, 5)}, 2'b00, 2'b01, 2'b01);
      end
      cyc();
      chk("n4_start", 2'b01, 2'b01, 2'b01, 2'b00);
      cyc();
      chk("n4_cnt1", 2'b01, 2'b00, 2'b01, 2'b00);

      // load 6 at cnt=1
      div_ld  = 2'b01;
      div_val = {16'd0, 16'd6};
      cyc();
      chk("ld6_cnt2", 2'b00, 2'b00, 2'b01, 2'b01);
      div_ld = 2'b00;
      cyc();
      chk("ld6_cnt3", 2'b00, 2'b00, 2'b01, 2'b01);
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk($sformatf("n6_k%0d", k), {1'b0, mclk(k, 6)}, {1'b0, mtick(k, 6)}, 2'b01, 2'b00);
      end

      // drop ch_en at cnt=1: period completes, then holds low
      cyc();
      chk("stop_k0", 2'b01, 2'b01, 2'b01, 2'b00);
      cyc();
      chk("stop_k1", 2'b01, 2'b00, 2'b01, 2'b00);
      ch_en = 2'b00;
      for (int k = 2; k < 6; k++) begin
         cyc();
         chk($sformatf("stop_k%0d", k), {1'b0, mclk(k, 6)}, 2'b00, 2'b01, 2'b00);
      end
      cyc();
      chk("stopped", 2'b00, 2'b00, 2'b00, 2'b00);
      cyc();
      chk("stopped_hold", 2'b00, 2'b00, 2'b00, 2'b00);
      ch_en = 2'b01;
      cyc();
      chk("restart", 2'b01, 2'b01, 2'b01, 2'b00);
      ch_en = 2'b00;
      for (int k = 1; k < 6; k++) begin
         cyc();
         chk($sformatf("restop_k%0d", k), {1'b0, mclk(k, 6)}, 2'b00, 2'b01, 2'b00);
      end
      cyc();
      chk("restopped", 2'b00, 2'b00, 2'b00, 2'b00);

      // ch1 at default 4: loads 0,1,3 back to back, last wins
      ch_en = 2'b10;
      cyc();
      chk("ch1_start", 2'b10, 2'b10, 2'b10, 2'b00);
      div_ld  = 2'b10;
      div_val = {16'd0, 16'd0};
      cyc();
      chk("ch1_ld0", 2'b10, 2'b00, 2'b10, 2'b10);
      div_val = {16'd1, 16'd0};
      cyc();
      chk("ch1_ld1", 2'b00, 2'b00, 2'b10, 2'b10);
      div_val = {16'd3, 16'd0};
      cyc();
      chk("ch1_ld3", 2'b00, 2'b00, 2'b10, 2'b10);
      div_ld = 2'b00;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk($sformatf("ch1_n3_k%0d", k), {mclk(k, 3), 1'b0}, {mtick(k, 3), 1'b0}, 2'b10, 2'b00);
      end

      // load 1 alone: clamped to 2
      div_ld  = 2'b10;
      div_val = {16'd1, 16'd0};
      cyc();
      chk("ch1_ld1_k0", 2'b10, 2'b10, 2'b10, 2'b10);
      div_ld = 2'b00;
      for (int k = 1; k < 3; k++) begin
         cyc();
         chk($sformatf("ch1_ld1_k%0d", k), {mclk(k, 3), 1'b0}, 2'b00, 2'b10, 2'b10);
      end
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk($sformatf("ch1_n2_k%0d", k), {mclk(k, 2), 1'b0}, {mtick(k, 2), 1'b0}, 2'b10, 2'b00);
      end

      // both channels: N=4 and N=7, then async reset mid-high
      ch_en = 2'b00;
      cyc();
      cyc();
      cyc();
      chk("both_idle", 2'b00, 2'b00, 2'b00, 2'b00);
      div_ld  = 2'b11;
      div_val = {16'd7, 16'd4};
      cyc();
      chk("both_idle_load", 2'b00, 2'b00, 2'b00, 2'b00);
      div_ld = 2'b00;
      ch_en  = 2'b11;
      for (int k = 0; k < 9; k++) begin
         cyc();
         chk($sformatf("dual_k%0d", k), {mclk(k, 7), mclk(k, 4)},
             {mtick(k, 7), mtick(k, 4)}, 2'b11, 2'b00);
      end
      div_ld  = 2'b01;
      div_val = {16'd0, 16'd5};
      cyc();
      chk("dual_pend", 2'b11, 2'b00, 2'b11, 2'b01);
      div_ld = 2'b00;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
      cyc();
      cyc();
      chk("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk($sformatf("post_rst_k%0d", k), {mclk(k, 4), mclk(k, 4)},
             {mtick(k, 4), mtick(k, 4)}, 2'b11, 2'b00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
